// File: rtl/demux_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : demux_pkg                                                  |
// | Description : Shared types and helpers for the registered stream demux.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package demux_pkg;

  // Packet-lock state: IDLE accepts a fresh direction, LOCKED reuses lock_dir.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Width of the direction field needed to address n channels.
  function automatic int sel_w(input int n);
    return $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : demux_slot                                                 |
// | Description : One-entry output register with valid/ready handshake.      |
// |               A fill wins over a drain in the same cycle, so a consumer  |
// |               taking the old beat never causes a bubble.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module demux_slot #(
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              drain_ready,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  // Load a new beat, otherwise release the held beat once the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      data  <= fill_data;
    end else if (valid && drain_ready) begin
      valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/demux_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : demux_reg                                                  |
// | Description : Registered 1-to-N stream demultiplexer with packet lock.   |
// |               Each accepted beat lands in the slot of the selected       |
// |               channel one cycle later; multi-beat packets keep the       |
// |               direction of their first beat until the last beat.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module demux_reg
  import demux_pkg::*;
#(
  parameter int DATA_W = 2,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = sel_w(N_OUT)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [DATA_W-1:0]       data_i,
  input  logic [SEL_W-1:0]        direction_i,
  input  logic                    valid_i,
  input  logic                    last_i,
  output logic                    ready_o,
  output logic [N_OUT*DATA_W-1:0] data_o,
  output logic [N_OUT-1:0]        valid_o,
  input  logic [N_OUT-1:0]        ready_i,
  output logic                    locked_o
);

  state_t           state;
  state_t           state_next;
  logic [SEL_W-1:0] lock_dir;
  logic [SEL_W-1:0] sel;
  logic             accept;
  logic [N_OUT-1:0] fill;

  // Inside a packet the held direction overrides direction_i.
  assign sel      = (state == LOCKED) ? lock_dir : direction_i;

  // Only the selected slot gates the source; other channels never stall it.
  assign ready_o  = !rst_i && (!valid_o[sel] || ready_i[sel]);
  assign accept   = valid_i && ready_o;
  assign locked_o = (state == LOCKED);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: enter LOCKED on the first beat of a multi-beat packet, leave on its last.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && !last_i) begin
          state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (accept && last_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the packet direction from its first beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_dir <= '0;
    end else if ((state == IDLE) && accept && !last_i) begin
      lock_dir <= direction_i;
    end
  end

  // One-hot fill strobe for the slot receiving the accepted beat.
  always_comb begin
    fill = '0;
    if (accept) begin
      fill[sel] = 1'b1;
    end
  end

  generate
    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
      demux_slot #(
        .DATA_W (DATA_W)
      ) u_slot (
        .clk         (clk_i),
        .rst         (rst_i),
        .fill        (fill[k]),
        .fill_data   (data_i),
        .drain_ready (ready_i[k]),
        .valid       (valid_o[k]),
        .data        (data_o[k*DATA_W +: DATA_W])
      );
    end
  endgenerate

endmodule
`default_nettype wire
